// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - ALU op codes and width helper shared by the arbiter and its bench
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_BNE = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_SRL = 4'b1100;

  // Requester index width; a single requester still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester and response handshake bundle
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  parameter int ID_W    = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [4*NUM_REQ-1:0]     req_ctrl;
  logic [32*NUM_REQ-1:0]    req_in_0;
  logic [32*NUM_REQ-1:0]    req_in_1;
  logic [TAG_W*NUM_REQ-1:0] req_tag;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic [31:0]              rsp_result;
  logic                     rsp_zero;

  // Requesters and response consumer side.
  modport master (
    output req_valid, req_ctrl, req_in_0, req_in_1, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_ctrl, req_in_0, req_in_1, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// rtl/alu_share_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_oh_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);

  int idx;

  // Walk ptr, ptr+1, ... (mod N) and take the first active request.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[idx]) begin
        any_o           = 1'b1;
        grant_idx_o     = IW'(idx);
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one combinational ALU with a single response slot
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus,
  output logic [3:0]           alu_ctrl_o,
  output logic [31:0]          alu_in_0_o,
  output logic [31:0]          alu_in_1_o,
  input  logic [31:0]          alu_result_i,
  input  logic                 alu_zero_i
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic [31:0]        rsp_result_q;
  logic               rsp_zero_q;

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               any_req;
  logic               slot_free;
  logic               transfer;
  logic [ID_W-1:0]    sel;
  int                 sel_int;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req_i       (bus.req_valid),
    .ptr_i       (ptr_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  assign slot_free     = !rsp_valid_q || bus.rsp_ready;
  assign bus.req_ready = (slot_free && !rst) ? grant_oh : '0;
  assign transfer      = any_req && slot_free && !rst;

  // Operand mux: the granted requester on a transfer, otherwise the pointer slice.
  always_comb begin
    sel        = transfer ? grant_idx : ptr_q;
    sel_int    = int'(sel);
    alu_ctrl_o = bus.req_ctrl[sel_int*4 +: 4];
    alu_in_0_o = bus.req_in_0[sel_int*32 +: 32];
    alu_in_1_o = bus.req_in_1[sel_int*32 +: 32];
  end

  // Next pointer: one past the granted requester, wrapping to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Response slot: load on transfer (drain+refill keeps valid), clear on drain only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else if (transfer) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= grant_idx;
      rsp_tag_q    <= bus.req_tag[int'(grant_idx)*TAG_W +: TAG_W];
      rsp_result_q <= alu_result_i;
      rsp_zero_q   <= alu_zero_i;
    end else if (bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for the shared-ALU arbiter
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NR   = 2;
  localparam int TW   = 4;
  localparam int IDW  = id_width(NR);

  typedef struct {
    int          id;
    logic [TW-1:0] tag;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_in_0, alu_in_1, alu_result;
  logic        alu_zero;

  alu_share_arbiter_if #(.NUM_REQ(NR), .TAG_W(TW)) bus ();

  alu_share_arbiter #(.NUM_REQ(NR), .TAG_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_ctrl_o   (alu_ctrl),
    .alu_in_0_o   (alu_in_0),
    .alu_in_1_o   (alu_in_1),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (c)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_BNE: r = a - b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR: r = ~(a | b);
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = b << a[4:0];
      ALU_SRA: r = $unsigned($signed(b) >>> a[4:0]);
      ALU_SRL: r = b >> a[4:0];
      default: r = 32'd0;
    endcase
    return {(c[2] ? (r == 32'd0) : (r != 32'd0)), r};
  endfunction

  // Parent-level ALU instance stand-in.
  always_comb {alu_zero, alu_result} = alu_fn(alu_ctrl, alu_in_0, alu_in_1);

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   m_ptr  = 0;
  logic m_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] t);
    bus.req_valid[i]           = 1'b1;
    bus.req_ctrl[4*i +: 4]     = c;
    bus.req_in_0[32*i +: 32]   = a;
    bus.req_in_1[32*i +: 32]   = b;
    bus.req_tag[TW*i +: TW]    = t;
  endtask

  // One cycle: check grant against the model at negedge, predict the response, advance.
  task automatic step();
    logic [NR-1:0] exp_rdy;
    logic          slot_free;
    logic [32:0]   r;
    exp_t          e;
    int            g;
    @(negedge clk);
    slot_free = !m_full || bus.rsp_ready;
    exp_rdy   = '0;
    g         = -1;
    if (slot_free && !rst) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_full));
    if (g >= 0) begin
      r      = alu_fn(bus.req_ctrl[4*g +: 4], bus.req_in_0[32*g +: 32], bus.req_in_1[32*g +: 32]);
      e.id   = g;
      e.tag  = bus.req_tag[TW*g +: TW];
      e.res  = r[31:0];
      e.zero = r[32];
      sb.push_back(e);
      m_ptr  = (g + 1) % NR;
      m_full = 1'b1;
    end else if (bus.rsp_ready && !rst) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) bus.req_valid[g] = 1'b0;
  endtask

  // Monitor: compare the presented response with the oldest expectation; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got id %0d with empty scoreboard", bus.rsp_id);
        end else begin
          check("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
          check("rsp_tag", 64'(bus.rsp_tag), 64'(sb[0].tag));
          check("rsp_result", 64'(bus.rsp_result), 64'(sb[0].res));
          check("rsp_zero", 64'(bus.rsp_zero), 64'(sb[0].zero));
          if (bus.rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic single(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] t, input logic [31:0] er, input logic ez, input string nm);
    set_req(i, c, a, b, t);
    step();
    check({nm, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({nm, "_id"}, 64'(bus.rsp_id), 64'(i));
    check({nm, "_tag"}, 64'(bus.rsp_tag), 64'(t));
    check({nm, "_result"}, 64'(bus.rsp_result), 64'(er));
    check({nm, "_zero"}, 64'(bus.rsp_zero), 64'(ez));
  endtask

  logic [3:0] ops [12] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_BNE, ALU_SUB, ALU_SLT,
                           ALU_NOR, ALU_XOR, ALU_SLL, ALU_SRA, ALU_SRL, 4'b0100};

  initial begin
    bus.req_valid = '0;
    bus.req_ctrl  = '0;
    bus.req_in_0  = '0;
    bus.req_in_1  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;

    // Reset with every requester valid.
    set_req(0, ALU_ADD, 32'd1, 32'd2, 4'd1);
    set_req(1, ALU_ADD, 32'd3, 32'd4, 4'd2);
    #3;
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_fields", {bus.rsp_result, 27'd0, bus.rsp_tag, bus.rsp_zero},
          64'd0);
    step();
    rst = 1'b0;
    step();
    check("first_grant_is_0", 64'(bus.rsp_id), 64'd0);
    step();
    step();
    step();

    // Single op from requester 0.
    single(0, ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b1, "add");

    // Contention: both valid every cycle, alternating grants.
    for (int c = 0; c < 4; c++) begin
      if (!bus.req_valid[0]) set_req(0, ALU_XOR, $urandom, $urandom, 4'(c));
      if (!bus.req_valid[1]) set_req(1, ALU_SUB, 32'd9, 32'd9, 4'(c + 8));
      step();
    end
    bus.req_valid = '0;
    step();

    // Backpressure: hold the slot full for 3 cycles, then drain and refill on one edge.
    set_req(1, ALU_OR, 32'h00F0, 32'h0F00, 4'd5);
    step();
    bus.rsp_ready = 1'b0;
    set_req(0, ALU_NOR, 32'd0, 32'd0, 4'd6);
    step();
    step();
    step();
    bus.rsp_ready = 1'b1;
    step();
    check("refill_valid", 64'(bus.rsp_valid), 64'd1);
    check("refill_tag", 64'(bus.rsp_tag), 64'd6);
    step();

    // Shifts, SLT and an undefined code.
    single(1, ALU_SRA, 32'd4, 32'h8000_0000, 4'd7, 32'hF800_0000, 1'b1, "sra");
    single(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd1, 1'b0, "slt");
    single(1, 4'b0100, 32'd123, 32'd456, 4'd9, 32'd0, 1'b1, "undef");
    step();

    // Randomized traffic with random response backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(1, 0) == 1)) begin
          logic [31:0] a;
          logic [31:0] b;
          a = $urandom;
          b = ($urandom_range(3, 0) == 0) ? a : $urandom;
          set_req(i, ops[$urandom_range(11, 0)], a, b, 4'($urandom));
        end
      end
      bus.rsp_ready = ($urandom_range(3, 0) != 0);
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    // Async reset mid-flight: pointer is 1 and the slot is full when rst rises.
    set_req(0, ALU_ADD, 32'd1, 32'd1, 4'd1);
    step();
    bus.rsp_ready = 1'b0;
    set_req(1, ALU_ADD, 32'd2, 32'd2, 4'd2);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("async_rst_req_ready", 64'(bus.req_ready), 64'd0);
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    set_req(0, ALU_AND, 32'hFF, 32'h0F, 4'd4);
    set_req(1, ALU_AND, 32'hF0, 32'hFF, 4'd5);
    bus.rsp_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("post_rst_grant_is_0", 64'(bus.rsp_id), 64'd0);
    step();
    check("post_rst_then_1", 64'(bus.rsp_id), 64'd1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
